// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush scheduler for load-use, taken branch and multi-cycle EX ops
module pipe_hazard_sched #(
    parameter int RA_W  = 5,
    parameter int LAT_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [RA_W-1:0]  ex_rt_i,
    input  logic             ex_br_taken_i,
    input  logic             ex_mc_start_i,
    input  logic [LAT_W-1:0] ex_mc_lat_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             ex_hold_o,
    output logic             mc_done_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {RUN = 2'd0, MC_BUSY = 2'd1, MC_DONE = 2'd2} state_t;

    state_t           state, state_nx;
    logic [LAT_W-1:0] cnt, cnt_nx;
    logic [LAT_W-1:0] lat_eff;
    logic             load_use;

    assign lat_eff  = (ex_mc_lat_i == '0) ? LAT_W'(1) : ex_mc_lat_i;
    assign load_use = ex_memread_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign state_o  = state;

    // Decode pipeline controls and next state; MC_DONE reuses RUN priority so a new op can issue back-to-back
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        idex_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        ex_hold_o    = 1'b0;
        mc_done_o    = 1'b0;
        state_nx     = RUN;
        cnt_nx       = cnt;
        if (rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            cnt_nx       = '0;
        end else if (state == MC_BUSY) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_write_o = 1'b0;
            ex_hold_o    = 1'b1;
            cnt_nx       = cnt - LAT_W'(1);
            state_nx     = (cnt == LAT_W'(1)) ? MC_DONE : MC_BUSY;
        end else begin
            mc_done_o = (state == MC_DONE);
            if (ex_br_taken_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (ex_mc_start_i) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_write_o = 1'b0;
                ex_hold_o    = 1'b1;
                cnt_nx       = lat_eff - LAT_W'(1);
                state_nx     = (lat_eff == LAT_W'(1)) ? MC_DONE : MC_BUSY;
            end else if (load_use) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end
        end
    end

    // Register FSM state and remaining multi-cycle latency
    always_ff @(posedge clk_i) begin
        state <= state_nx;
        cnt   <= cnt_nx;
    end

    // Saturating count of cycles where the PC is held, reset cycles excluded
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if (!pc_write_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: randomized and directed checks against a cycle-level reference model
module tb_pipe_hazard_sched;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
    logic       id_uses_rt_i, ex_memread_i, ex_br_taken_i, ex_mc_start_i;
    logic [5:0] ex_mc_lat_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o, ex_hold_o, mc_done_o;
    logic [1:0] state_o;
    logic [15:0] stall_cnt_o;

    int n_pass = 0;
    int n_total = 0;
    int busy_left = 0;
    bit done_now = 1'b0;
    int scnt = 0;
    bit cnt_known = 1'b0;

    pipe_hazard_sched dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .ex_br_taken_i(ex_br_taken_i),
        .ex_mc_start_i(ex_mc_start_i), .ex_mc_lat_i(ex_mc_lat_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_write_o(idex_write_o), .idex_flush_o(idex_flush_o), .ex_hold_o(ex_hold_o),
        .mc_done_o(mc_done_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive(input logic r, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br, input logic st,
                         input logic [5:0] lat);
        rst_i = r; ex_memread_i = mr; ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt;
        id_uses_rt_i = urt; ex_br_taken_i = br; ex_mc_start_i = st; ex_mc_lat_i = lat;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare this cycle's outputs with the model, then clock and advance the model
    task automatic tick();
        logic [6:0] e;
        int st, lat;
        bit lu;
        #2;
        lu = ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
        st = 0;
        if (rst_i) e = 7'b0010100;
        else if (busy_left > 0) begin e = 7'b0000010; st = 1; end
        else begin
            st = done_now ? 2 : 0;
            if (ex_br_taken_i) e = 7'b1111100;
            else if (ex_mc_start_i) e = 7'b0000010;
            else if (lu) e = 7'b0001100;
            else e = 7'b1101000;
            e[0] = done_now;
        end
        check("ctl", {25'b0, pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
                      ex_hold_o, mc_done_o}, {25'b0, e});
        if (!rst_i) check("state", {30'b0, state_o}, st);
        if (cnt_known) check("stall_cnt", {16'b0, stall_cnt_o}, scnt);
        if (rst_i) begin
            busy_left = 0; done_now = 0; scnt = 0; cnt_known = 1;
        end else begin
            if (!e[6] && scnt < 65535) scnt++;
            if (busy_left > 0) begin
                busy_left--;
                done_now = (busy_left == 0);
            end else if (!ex_br_taken_i && ex_mc_start_i) begin
                lat = (ex_mc_lat_i == 0) ? 1 : int'(ex_mc_lat_i);
                busy_left = lat - 1;
                done_now = (lat == 1);
            end else done_now = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        tick(); tick();
        idle(); tick();
        // load-use on rs, then clear
        drive(0, 1, 8, 8, 3, 0, 0, 0, 0); tick();
        idle(); tick();
        check("lu_stall_cnt", {16'b0, stall_cnt_o}, 1);
        // load-use through rt, and rt match ignored when rt not used
        drive(0, 1, 9, 1, 9, 1, 0, 0, 0); tick();
        drive(0, 1, 9, 1, 9, 0, 0, 0, 0); tick();
        // load to $0 never stalls
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0); tick();
        // branch wins over load-use
        drive(0, 1, 8, 8, 0, 0, 1, 0, 0); tick();
        // branch wins over mc start
        drive(0, 0, 0, 0, 0, 0, 1, 1, 4); tick();
        // mult lat 4, inputs noisy during busy
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4); tick();
        drive(0, 1, 8, 8, 0, 0, 1, 1, 9); tick(); tick(); tick();
        idle(); tick();
        // lat 0 behaves as 1
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        idle(); tick(); tick();
        // back-to-back: lat 3 then lat 2 issued in MC_DONE
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
        idle(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2); tick();
        idle(); tick(); tick(); tick();
        // reset while busy with cnt=5
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
        idle(); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        idle(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 6)));
            tick();
        end
        // saturation: continuous load-use stall
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) tick();
        check("sat", {16'b0, stall_cnt_o}, 32'h0000ffff);
        idle(); tick();
        check("sat_hold", {16'b0, stall_cnt_o}, 32'h0000ffff);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
